mc_ctrl: RTL and testbench

Multi-cycle control unit and program sequencer for the 16-bit datapath. It fetches instructions over a ready-handshake memory port and decodes them. It drives the ALU function select (fnsel) and operand-B mux, latches the ALU result and carry outputs into an internal result register and flags, and sequences register-file writeback, loads, stores and branches. It sits directly upstream of the ALU and owns PC, IR, the ALU result register, the memory data register and the flags.

---
 rtl/mc_ctrl.sv | 114 +++++++++++
 tb/tb_mc_ctrl.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle control unit and program sequencer for the 16-bit datapath
module mc_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] mem_rdata,
  input  logic        mem_ready,
  input  logic [15:0] alu_z,
  input  logic        alu_c_n,
  input  logic        alu_c_n_minus_1,
  output logic [15:0] pc,
  output logic [15:0] ir,
  output logic        mem_req,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [2:0]  alu_fnsel,
  output logic        alu_srcb,
  output logic [15:0] imm16,
  output logic [3:0]  rf_ra,
  output logic [3:0]  rf_rb,
  output logic [3:0]  rf_wa,
  output logic        rf_we,
  output logic [15:0] rf_wdata,
  output logic [2:0]  flags,
  output logic        halted,
  output logic        illegal
);
  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, HLT} state_t;
  state_t state, state_nx;
  logic run;
  logic [15:0] alu_out, mdr;
  logic [3:0] op;
  logic [15:0] simm8;
  logic is_br, is_mem, arith, logic_op, bad, taken;
  logic [2:0] fn;
  assign op       = ir[15:12];
  assign imm16    = {{12{ir[3]}}, ir[3:0]};
  assign simm8    = {{8{ir[7]}}, ir[7:0]};
  assign rf_ra    = ir[7:4];
  assign rf_rb    = op == 4'h8 ? ir[11:8] : ir[3:0];
  assign rf_wa    = ir[11:8];
  assign rf_wdata = op == 4'h7 ? mdr : alu_out;
  assign is_br    = op == 4'h9 || op == 4'hA || op == 4'hB;
  assign is_mem   = op == 4'h7 || op == 4'h8;
  assign arith    = op == 4'h0 || op == 4'h1 || op == 4'h6;
  assign logic_op = op >= 4'h2 && op <= 4'h5;
  assign bad      = op >= 4'hC && op <= 4'hE;
  assign taken    = op == 4'h9 ? flags[1] : op == 4'hA ? flags[0] : op == 4'hB;
  assign fn       = op <= 4'h3 ? op[2:0] : op == 4'h4 ? 3'd5 : op == 4'h5 ? 3'd6 : 3'd0;
  // state register; run holds off the first request until one edge after reset release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= FETCH;
    else state <= state_nx;
  end
  // next-state and strobes
  always_comb begin
    state_nx  = state;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = pc;
    alu_fnsel = 3'd6;
    alu_srcb  = 1'b0;
    rf_we     = 1'b0;
    halted    = 1'b0;
    case (state)
      FETCH: begin
        mem_req  = run;
        state_nx = run && mem_ready ? DECODE : FETCH;
      end
      DECODE: state_nx = op == 4'hF || bad ? HLT : EXEC;
      EXEC: begin
        alu_fnsel = fn;
        alu_srcb  = op == 4'h6 || is_mem;
        state_nx  = is_br ? FETCH : is_mem ? MEM : WB;
      end
      MEM: begin
        mem_req  = 1'b1;
        mem_we   = op == 4'h8;
        mem_addr = alu_out;
        state_nx = !mem_ready ? MEM : op == 4'h7 ? WB : FETCH;
      end
      WB: begin
        rf_we    = 1'b1;
        state_nx = FETCH;
      end
      default: halted = 1'b1;
    endcase
  end
  // pc, ir, result/data registers and flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run     <= 1'b0;
      pc      <= 16'd0;
      ir      <= 16'd0;
      alu_out <= 16'd0;
      mdr     <= 16'd0;
      flags   <= 3'd0;
      illegal <= 1'b0;
    end else begin
      run <= 1'b1;
      if (state == FETCH && run && mem_ready) begin
        ir <= mem_rdata;
        pc <= pc + 16'd1;
      end
      if (state == DECODE && bad) illegal <= 1'b1;
      if (state == EXEC) begin
        alu_out <= alu_z;
        if (taken) pc <= pc + simm8;
        if (arith) flags <= {alu_c_n ^ alu_c_n_minus_1, alu_z == 16'd0, alu_c_n};
        else if (logic_op) flags[1] <= alu_z == 16'd0;
      end
      if (state == MEM && mem_ready && op == 4'h7) mdr <= mem_rdata;
    end
  end
endmodule

// File: tb/tb_mc_ctrl.sv
// tb_mc_ctrl: random and directed programs checked against an instruction-level model
module tb_mc_ctrl;
  logic clk = 1'b0, rst_n = 1'b0, mem_ready = 1'b0;
  logic [15:0] mem_rdata, alu_z, pc, ir, mem_addr, imm16, rf_wdata;
  logic alu_c_n, alu_c_n_minus_1, mem_req, mem_we, alu_srcb, rf_we, halted, illegal;
  logic [2:0] alu_fnsel, flags;
  logic [3:0] rf_ra, rf_rb, rf_wa;
  logic [15:0] mem [65536];
  logic [15:0] m_mem [65536];
  logic [15:0] rf [16];
  logic [15:0] m_rf [16];
  logic [15:0] m_pc;
  logic [2:0] m_flags;
  logic m_halt, m_ill;
  logic [3:0] q_wa [$];
  logic [15:0] q_wd [$];
  logic pend, p_we;
  logic [15:0] p_addr, p_wd;
  int plen, hc, n_cmp = 0, n_bad = 0;
  logic [15:0] a, b, bb;
  logic [16:0] s;
  logic [15:0] s14;
  mc_ctrl dut (
    .clk(clk), .rst_n(rst_n), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .alu_z(alu_z), .alu_c_n(alu_c_n), .alu_c_n_minus_1(alu_c_n_minus_1),
    .pc(pc), .ir(ir), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .alu_fnsel(alu_fnsel), .alu_srcb(alu_srcb), .imm16(imm16),
    .rf_ra(rf_ra), .rf_rb(rf_rb), .rf_wa(rf_wa), .rf_we(rf_we), .rf_wdata(rf_wdata),
    .flags(flags), .halted(halted), .illegal(illegal)
  );
  always #5 clk = ~clk;
  assign mem_rdata = mem[mem_addr];
  // environment ALU fed by the environment register file
  always_comb begin
    a   = rf[rf_ra];
    b   = alu_srcb ? imm16 : rf[rf_rb];
    bb  = alu_fnsel == 3'd1 ? ~b : b;
    s   = {1'b0, a} + {1'b0, bb} + {16'd0, alu_fnsel == 3'd1};
    s14 = {1'b0, a[14:0]} + {1'b0, bb[14:0]} + {15'd0, alu_fnsel == 3'd1};
    alu_z = alu_fnsel <= 3'd1 ? s[15:0] : alu_fnsel == 3'd2 ? a & b : alu_fnsel == 3'd3 ? a | b :
            alu_fnsel == 3'd5 ? ~a : a;
    alu_c_n = alu_fnsel <= 3'd1 && s[16];
    alu_c_n_minus_1 = alu_fnsel <= 3'd1 && s14[15];
  end
  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic put(input int ad, input logic [15:0] v);
    mem[ad] = v;
    m_mem[ad] = v;
  endtask
  task automatic setr(input int i, input logic [15:0] v);
    rf[i] = v;
    m_rf[i] = v;
  endtask
  task automatic init(input bit rnd);
    for (int i = 0; i < 65536; i++) put(i, rnd ? 16'($urandom) : 16'hF000);
    for (int i = 0; i < 16; i++) setr(i, 16'($urandom));
    q_wa.delete();
    q_wd.delete();
    pend = 0; m_pc = 0; m_flags = 0; m_halt = 0; m_ill = 0; plen = 0; hc = -1;
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    mem_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_mem_req", mem_req, 0); chk("rst_mem_we", mem_we, 0); chk("rst_rf_we", rf_we, 0);
    chk("rst_halted", halted, 0); chk("rst_illegal", illegal, 0); chk("rst_pc", pc, 0);
    chk("rst_ir", ir, 0); chk("rst_flags", flags, 0);
    rst_n = 1'b1;
  endtask
  // executes one instruction at the architectural level
  task automatic step();
    logic [15:0] in, x, y, r, s4, s8;
    logic [16:0] w;
    logic [3:0] o, rd;
    in = m_mem[m_pc];
    m_pc = m_pc + 1;
    o = in[15:12]; rd = in[11:8];
    x = m_rf[in[7:4]]; y = m_rf[in[3:0]];
    s4 = {{12{in[3]}}, in[3:0]};
    s8 = {{8{in[7]}}, in[7:0]};
    if (o == 4'h6) y = s4;
    plen = 4;
    if (o == 4'h0 || o == 4'h6) begin
      w = x + y; r = w[15:0];
      m_flags = {x[15] == y[15] && r[15] != x[15], r == 0, w[16]};
    end else if (o == 4'h1) begin
      r = x - y;
      m_flags = {x[15] != y[15] && r[15] != x[15], r == 0, x >= y};
    end else begin
      r = o == 4'h2 ? x & y : o == 4'h3 ? x | y : o == 4'h4 ? ~x : x;
      if (o >= 4'h2 && o <= 4'h5) m_flags[1] = r == 0;
    end
    if (o <= 4'h6) begin
      q_wa.push_back(rd); q_wd.push_back(r); m_rf[rd] = r;
    end else if (o == 4'h7) begin
      p_addr = x + s4; p_we = 0; pend = 1; plen = 5;
      q_wa.push_back(rd); q_wd.push_back(m_mem[p_addr]); m_rf[rd] = m_mem[p_addr];
    end else if (o == 4'h8) begin
      p_addr = x + s4; p_we = 1; p_wd = m_rf[rd]; pend = 1;
      m_mem[p_addr] = p_wd;
    end else if (o <= 4'hB) begin
      plen = 3;
      if (o == 4'hB || (o == 4'h9 && m_flags[1]) || (o == 4'hA && m_flags[0])) m_pc = m_pc + s8;
    end else begin
      m_halt = 1; m_ill = o != 4'hF; hc = 0;
    end
  endtask
  // drives memory, monitors the DUT cycle by cycle and checks against the model
  task automatic run(input int max_i, input bit zw, output int first_we);
    int cyc = 0, n = 0, last = 0;
    bit hold = 0, stop = 0;
    logic [15:0] pa;
    logic pw;
    first_we = 0;
    while (!stop) begin
      @(negedge clk);
      cyc++;
      mem_ready = zw || $urandom_range(0, 2) != 0;
      if (cyc == 1) chk("req_first_edge", mem_req, 1);
      if (hold && mem_req) begin
        chk("addr_hold", mem_addr, pa); chk("we_hold", mem_we, pw);
      end
      hold = mem_req && !mem_ready; pa = mem_addr; pw = mem_we;
      if (rf_we) begin
        if (first_we == 0) first_we = cyc;
        if (q_wa.size() == 0) chk("rf_we_spurious", 1, 0);
        else begin
          chk("rf_wa", rf_wa, q_wa.pop_front()); chk("rf_wdata", rf_wdata, q_wd.pop_front());
        end
        rf[rf_wa] = rf_wdata;
      end
      if (hc >= 0) begin
        hc++;
        chk("halt_no_req", mem_req, 0);
        if (hc == 1) chk("halted_early", halted, 0);
        if (hc == 2) begin
          chk("halted", halted, 1); chk("illegal", illegal, m_ill);
        end
        if (hc == 5) stop = 1;
      end else if (mem_req && mem_ready) begin
        if (pend) begin
          chk("data_addr", mem_addr, p_addr); chk("data_we", mem_we, p_we);
          if (p_we) begin
            chk("st_data", rf[rf_rb], p_wd);
            mem[mem_addr] = rf[rf_rb];
          end
          pend = 0;
        end else begin
          chk("fetch_pc", mem_addr, m_pc); chk("fetch_we", mem_we, 0);
          chk("flags", flags, m_flags);
          if (zw && n > 0) chk("cycles", cyc - last, plen);
          last = cyc;
          step();
          n++;
          if (n > max_i) stop = 1;
        end
      end
      if (cyc >= 8000) begin
        chk("timeout", 1, 0);
        stop = 1;
      end
    end
    if (m_halt) begin
      chk("end_wb_left", q_wa.size(), 0); chk("end_flags", flags, m_flags); chk("end_pc", pc, m_pc);
    end
  endtask
  initial begin
    int fw;
    init(0);
    do_reset();
    // ADDI r1,r0,5 then HALT
    setr(0, 16'd0); put(0, 16'h6105); put(1, 16'hF000);
    run(10, 1, fw);
    chk("addi_we_cycle", fw, 4); chk("addi_pc", pc, 16'd2); chk("addi_flags", flags, 3'b000);
    // SUB overflow, then AND with zero result
    init(0); do_reset();
    setr(1, 16'h8000); setr(2, 16'h0001);
    put(0, 16'h1312); put(1, 16'h2412); put(2, 16'hF000);
    run(10, 1, fw);
    chk("sub_and_flags", flags, 3'b111);
    // BZ at pc=4, taken and not taken
    for (int z = 0; z < 2; z++) begin
      init(0); do_reset();
      setr(0, z ? 16'd1 : 16'd0);
      put(0, 16'h5000); put(1, 16'hB002); put(2, 16'h0000); put(4, 16'h90FE);
      run(10, 1, fw);
      chk("bz_end_pc", pc, z ? 16'd6 : 16'd4);
    end
    // illegal opcode and plain halt
    init(0); do_reset(); put(0, 16'hC000); run(4, 0, fw); chk("ill_flag", illegal, 1);
    init(0); do_reset(); put(0, 16'hF000); run(4, 0, fw); chk("halt_ill", illegal, 0);
    // random programs, alternating zero-wait and random wait states
    for (int r = 0; r < 6; r++) begin
      init(1);
      for (int i = 0; i < 96; i++) put(i, {4'($urandom_range(0, 11)), 12'($urandom)});
      do_reset();
      run(200, r[0], fw);
    end
    // reset asserted mid-LD while memory is stalled
    init(0); do_reset();
    setr(0, 16'h1234); put(0, 16'h7100);
    mem_ready = 1'b1;
    repeat (2) @(negedge clk);
    mem_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("mid_req", mem_req, 1); chk("mid_addr", mem_addr, 16'h1234);
    #2 rst_n = 1'b0;
    #1;
    chk("async_req", mem_req, 0); chk("async_pc", pc, 0); chk("async_ir", ir, 0);
    chk("async_flags", flags, 0); chk("async_we", mem_we, 0); chk("async_rf_we", rf_we, 0);
    @(negedge clk);
    rst_n = 1'b1;
    mem_ready = 1'b1;
    @(negedge clk);
    chk("refetch_req", mem_req, 1); chk("refetch_addr", mem_addr, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
